// File: rtl/spi_ms_pkg.sv
// Shared constants, FSM state type and divider lookup for the SPI shift engine.
package spi_ms_pkg;
  localparam int DATA_W = 16;
  localparam int DIV_00 = 4;
  localparam int DIV_01 = 0;
  localparam int DIV_10 = 9;
  localparam int DIV_11 = 24;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  function automatic logic [CNT_W-1:0] div_sel(input logic [1:0] fc,
                                               input int d00, input int d01,
                                               input int d10, input int d11);
    case (fc)
      2'b00:   div_sel = CNT_W'(d00);
      2'b01:   div_sel = CNT_W'(d01);
      2'b10:   div_sel = CNT_W'(d10);
      default: div_sel = CNT_W'(d11);
    endcase
  endfunction
endpackage

// File: rtl/spi_sclk_gen.sv
// sclk divider: toggles sclk every div+1 clk cycles while en; strobes mark the toggling cycle.
module spi_sclk_gen
  import spi_ms_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  output logic             sclk,
  output logic             rise,
  output logic             fall
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             hit;

  // Strobes are combinational so the top acts on the same edge sclk toggles.
  assign hit  = en && (cnt_q == div);
  assign rise = hit & ~sclk_q;
  assign fall = hit & sclk_q;
  assign sclk = sclk_q;

  always_comb begin
    cnt_d  = '0;
    sclk_d = 1'b0;
    if (en) begin
      cnt_d  = hit ? '0 : cnt_q + 1'b1;
      sclk_d = sclk_q ^ hit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end
endmodule

// File: rtl/spi_master_slave_ctrl.sv
// SPI mode-0 shift engine, DATA_W bits per transfer, TX and/or RX.
// Define SPI_LSB_FIRST_EN for LSB-first shifting in both directions.
module spi_master_slave_ctrl
  import spi_ms_pkg::*;
#(
  parameter int DIV_00_P = DIV_00,
  parameter int DIV_01_P = DIV_01,
  parameter int DIV_10_P = DIV_10,
  parameter int DIV_11_P = DIV_11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              slave_rx_start,
  input  logic              slave_tx_start,
  input  logic [DATA_W-1:0] miso_reg_data,
  input  logic              mosi,
  input  logic [1:0]        freq_control,
  input  logic              cs_bar,
  output logic              sclk,
  output logic              miso,
  output logic [DATA_W-1:0] mosi_reg_data,
  output logic              rx_valid,
  output logic              tx_done
);
  localparam int BIT_W = $clog2(DATA_W);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    div_q, div_d;
  logic                tx_en_q, tx_en_d, rx_en_q, rx_en_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                miso_q, miso_d;
  logic [DATA_W-1:0]   mosi_reg_data_q, mosi_reg_data_d;
  logic                rx_valid_q, rx_valid_d, tx_done_q, tx_done_d;
  logic                start, sclk_rise, sclk_fall;

  assign start = (slave_tx_start | slave_rx_start) & cs_bar;

  spi_sclk_gen u_sclk (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == SHIFT),
    .div   (div_q),
    .sclk  (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  always_comb begin
    state_d         = state_q;
    div_d           = div_q;
    tx_en_d         = tx_en_q;
    rx_en_d         = rx_en_q;
    tx_sr_d         = tx_sr_q;
    rx_sr_d         = rx_sr_q;
    bit_cnt_d       = bit_cnt_q;
    miso_d          = miso_q;
    mosi_reg_data_d = mosi_reg_data_q;
    rx_valid_d      = rx_valid_q;
    tx_done_d       = tx_done_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d    = SHIFT;
          tx_en_d    = slave_tx_start;
          rx_en_d    = slave_rx_start;
          tx_sr_d    = miso_reg_data;
          rx_sr_d    = '0;
          bit_cnt_d  = '0;
          div_d      = div_sel(freq_control, DIV_00_P, DIV_01_P, DIV_10_P, DIV_11_P);
          rx_valid_d = 1'b0;
          tx_done_d  = 1'b0;
`ifdef SPI_LSB_FIRST_EN
          if (slave_tx_start) miso_d = miso_reg_data[0];
`else
          if (slave_tx_start) miso_d = miso_reg_data[DATA_W-1];
`endif
        end
      end
      SHIFT: begin
        if (sclk_rise && rx_en_q) begin
`ifdef SPI_LSB_FIRST_EN
          rx_sr_d = {mosi, rx_sr_q[DATA_W-1:1]};
`else
          rx_sr_d = {rx_sr_q[DATA_W-2:0], mosi};
`endif
        end
        if (sclk_fall) begin
          // Last falling edge: no further bit, miso keeps the final one.
          if (bit_cnt_q == BIT_W'(DATA_W-1)) begin
            state_d = DONE;
            if (rx_en_q) begin
              mosi_reg_data_d = rx_sr_q;
              rx_valid_d      = 1'b1;
            end
            if (tx_en_q) tx_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (tx_en_q) begin
`ifdef SPI_LSB_FIRST_EN
              tx_sr_d = tx_sr_q >> 1;
              miso_d  = tx_sr_q[1];
`else
              tx_sr_d = tx_sr_q << 1;
              miso_d  = tx_sr_q[DATA_W-2];
`endif
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      div_q           <= '0;
      tx_en_q         <= 1'b0;
      rx_en_q         <= 1'b0;
      tx_sr_q         <= '0;
      rx_sr_q         <= '0;
      bit_cnt_q       <= '0;
      miso_q          <= 1'b0;
      mosi_reg_data_q <= '0;
      rx_valid_q      <= 1'b0;
      tx_done_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      div_q           <= div_d;
      tx_en_q         <= tx_en_d;
      rx_en_q         <= rx_en_d;
      tx_sr_q         <= tx_sr_d;
      rx_sr_q         <= rx_sr_d;
      bit_cnt_q       <= bit_cnt_d;
      miso_q          <= miso_d;
      mosi_reg_data_q <= mosi_reg_data_d;
      rx_valid_q      <= rx_valid_d;
      tx_done_q       <= tx_done_d;
    end
  end

  assign miso          = miso_q;
  assign mosi_reg_data = mosi_reg_data_q;
  assign rx_valid      = rx_valid_q;
  assign tx_done       = tx_done_q;
endmodule

// File: tb/tb_spi_master_slave_ctrl.sv
// Directed bench for spi_master_slave_ctrl acting as the external SPI peer.
module tb_spi_master_slave_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        slave_rx_start, slave_tx_start, mosi, cs_bar;
  logic [15:0] miso_reg_data;
  logic [1:0]  freq_control;
  logic        sclk, miso, rx_valid, tx_done;
  logic [15:0] mosi_reg_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_master_slave_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .slave_rx_start (slave_rx_start),
    .slave_tx_start (slave_tx_start),
    .miso_reg_data  (miso_reg_data),
    .mosi           (mosi),
    .freq_control   (freq_control),
    .cs_bar         (cs_bar),
    .sclk           (sclk),
    .miso           (miso),
    .mosi_reg_data  (mosi_reg_data),
    .rx_valid       (rx_valid),
    .tx_done        (tx_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic first_bit(input logic [15:0] w);
`ifdef SPI_LSB_FIRST_EN
    return w[0];
`else
    return w[15];
`endif
  endfunction

  function automatic logic last_bit(input logic [15:0] w);
`ifdef SPI_LSB_FIRST_EN
    return w[15];
`else
    return w[0];
`endif
  endfunction

  // Runs one transfer as the peer: drives mosi on sclk falls, collects miso on sclk rises.
  task automatic xfer(input logic tx, input logic rx, input logic [15:0] txw,
                      input logic [15:0] rxw, input logic [1:0] fc,
                      input int glitch_at, input int abort_at,
                      output logic [15:0] got, output int rises, output int hi);
    logic prev;
    int   falls;
    bit   finished;
    got = '0; rises = 0; hi = 0; falls = 0; finished = 0;
    @(posedge clk); #1;
    miso_reg_data = txw; freq_control = fc; mosi = first_bit(rxw);
    slave_tx_start = tx; slave_rx_start = rx; cs_bar = 1'b1;
    @(posedge clk); #1;
    slave_tx_start = 1'b0; slave_rx_start = 1'b0;
    miso_reg_data = ~txw; freq_control = ~fc;
    prev = sclk;
    for (int c = 0; c < 2000; c++) begin
      slave_tx_start = 1'b0;
      if ((tx && tx_done) || (!tx && rx_valid)) begin
        finished = 1;
        break;
      end
      if (sclk && !prev) begin
        rises++;
`ifdef SPI_LSB_FIRST_EN
        got = {miso, got[15:1]};
`else
        got = {got[14:0], miso};
`endif
        if (rises == glitch_at) slave_tx_start = 1'b1;
        if (rises == abort_at) begin
          reset = 1'b1;
          #1;
          finished = 1;
          break;
        end
      end
      if (!sclk && prev) begin
        falls++;
`ifdef SPI_LSB_FIRST_EN
        if (falls < 16) mosi = rxw[falls];
`else
        if (falls < 16) mosi = rxw[15-falls];
`endif
      end
      if (sclk) hi++;
      prev = sclk;
      @(posedge clk); #1;
    end
    chk("xfer_completes", {31'd0, finished}, 32'd1);
  endtask

  initial begin
    logic [15:0] got;
    int rises, hi, toggles;
    logic prev;
    reset = 1'b1; slave_rx_start = 1'b0; slave_tx_start = 1'b0;
    miso_reg_data = '0; mosi = 1'b0; freq_control = 2'b01; cs_bar = 1'b1;
    #1;
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_rxdata", {16'd0, mosi_reg_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_tx_done", {31'd0, tx_done}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;

    // TX only, fastest clock
    xfer(1'b1, 1'b0, 16'h55AA, 16'h0000, 2'b01, 0, 0, got, rises, hi);
    chk("tx_word", {16'd0, got}, 32'h55AA);
    chk("tx_rises", rises, 16);
    chk("tx_hi_cycles", hi, 16);
    chk("tx_done", {31'd0, tx_done}, 32'd1);
    chk("tx_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("tx_miso_idle", {31'd0, miso}, {31'd0, last_bit(16'h55AA)});

    // RX only
    xfer(1'b0, 1'b1, 16'h0000, 16'hA55A, 2'b01, 0, 0, got, rises, hi);
    chk("rx_word", {16'd0, mosi_reg_data}, 32'hA55A);
    chk("rx_rises", rises, 16);
    chk("rx_valid", {31'd0, rx_valid}, 32'd1);
    chk("rx_tx_done", {31'd0, tx_done}, 32'd0);
    chk("rx_miso_hold", {31'd0, miso}, {31'd0, last_bit(16'h55AA)});

    // TX+RX together
    xfer(1'b1, 1'b1, 16'h1234, 16'h5678, 2'b01, 0, 0, got, rises, hi);
    chk("trx_tx_word", {16'd0, got}, 32'h1234);
    chk("trx_rx_word", {16'd0, mosi_reg_data}, 32'h5678);
    chk("trx_rx_valid", {31'd0, rx_valid}, 32'd1);
    chk("trx_tx_done", {31'd0, tx_done}, 32'd1);

    // Slowest divider: 25-cycle half period
    xfer(1'b1, 1'b0, 16'hABCD, 16'h0000, 2'b11, 0, 0, got, rises, hi);
    chk("slow_tx_word", {16'd0, got}, 32'hABCD);
    chk("slow_hi_cycles", hi, 400);
    chk("slow_tx_done", {31'd0, tx_done}, 32'd1);
    chk("slow_rx_cleared", {31'd0, rx_valid}, 32'd0);
    chk("slow_rxdata_kept", {16'd0, mosi_reg_data}, 32'h5678);
    chk("slow_miso_idle", {31'd0, miso}, {31'd0, last_bit(16'hABCD)});

    // Start with bus busy (cs_bar=0) is ignored
    @(posedge clk); #1;
    cs_bar = 1'b0; slave_tx_start = 1'b1; miso_reg_data = 16'hFFFF;
    @(posedge clk); #1;
    slave_tx_start = 1'b0;
    toggles = 0; prev = sclk;
    for (int c = 0; c < 60; c++) begin
      if (sclk != prev) toggles++;
      prev = sclk;
      @(posedge clk); #1;
    end
    cs_bar = 1'b1;
    chk("csb_no_sclk", toggles, 0);
    chk("csb_tx_done_kept", {31'd0, tx_done}, 32'd1);
    chk("csb_rx_valid_kept", {31'd0, rx_valid}, 32'd0);

    // Start pulse mid-transfer ignored; divider 00 -> 5-cycle half period
    xfer(1'b1, 1'b1, 16'h0F0F, 16'hF00F, 2'b00, 5, 0, got, rises, hi);
    chk("glitch_tx_word", {16'd0, got}, 32'h0F0F);
    chk("glitch_rx_word", {16'd0, mosi_reg_data}, 32'hF00F);
    chk("glitch_rises", rises, 16);
    chk("glitch_hi_cycles", hi, 80);

    // Reset at bit 8 aborts to reset values
    xfer(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 2'b01, 0, 8, got, rises, hi);
    chk("abort_sclk", {31'd0, sclk}, 32'd0);
    chk("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("abort_tx_done", {31'd0, tx_done}, 32'd0);
    chk("abort_rxdata", {16'd0, mosi_reg_data}, 32'd0);
    chk("abort_miso", {31'd0, miso}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;

    // Normal transfer after abort, divider 10 -> 10-cycle half period
    xfer(1'b1, 1'b1, 16'hC3A5, 16'h3C5A, 2'b10, 0, 0, got, rises, hi);
    chk("post_tx_word", {16'd0, got}, 32'hC3A5);
    chk("post_rx_word", {16'd0, mosi_reg_data}, 32'h3C5A);
    chk("post_hi_cycles", hi, 160);
    chk("post_flags", {30'd0, rx_valid, tx_done}, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
